// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Defines the stored FIFO entry layout, the trigger-level encoding and thresholds.

package uart_pkg;

    // One received character plus its per-character line errors.
    typedef struct packed {
        logic       bi;
        logic       fe;
        logic       pe;
        logic [7:0] data;
    } rx_entry_t;

    // Receive interrupt trigger-level select.
    typedef enum logic [1:0] {
        TRIG_LVL_1  = 2'b00,
        TRIG_LVL_4  = 2'b01,
        TRIG_LVL_8  = 2'b10,
        TRIG_LVL_14 = 2'b11
    } trig_lvl_e;

    localparam logic [7:0] TRIG_T1  = 8'd1;
    localparam logic [7:0] TRIG_T4  = 8'd4;
    localparam logic [7:0] TRIG_T8  = 8'd8;
    localparam logic [7:0] TRIG_T14 = 8'd14;

    // Occupancy threshold for a trigger level (before capacity clamping).
    function automatic logic [7:0] trig_threshold(input trig_lvl_e lvl);
        logic [7:0] thr;
        thr = TRIG_T1;
        unique case (lvl)
            TRIG_LVL_1:  thr = TRIG_T1;
            TRIG_LVL_4:  thr = TRIG_T4;
            TRIG_LVL_8:  thr = TRIG_T8;
            TRIG_LVL_14: thr = TRIG_T14;
            default:     thr = TRIG_T1;
        endcase
        return thr;
    endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// Character-timeout counter for the receive FIFO.
// Ports: clk, rst (sync, high), baud_pulse (16x tick), empty, activity
// (push/pop/flush), timeout (held until next activity).

module uart_rx_timeout
    import uart_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 640
) (
    input  logic clk,
    input  logic rst,
    input  logic baud_pulse,
    input  logic empty,
    input  logic activity,
    output logic timeout
);

    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_TICKS);

    logic [TW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (activity || empty) begin
            cnt_d     = '0;
            timeout_d = 1'b0;
        end else begin
            // Counter saturates at the limit so timeout stays asserted.
            if (baud_pulse && (cnt_q != LIMIT)) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_d == LIMIT) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with per-entry error flags, overrun, trigger and timeout.
// Ports: clk, rst (sync, high), baud_pulse, push/din/pe_in/fe_in/bi_in from the
// receiver; pop, fifo_en, fifo_clr, trig_lvl, lsr_rd from the host; dout and
// head flags (fall-through), empty, full, count, overrun, trig, err_in_fifo,
// timeout. Define UART_RX_TIMEOUT_EN to build the character-timeout counter;
// otherwise timeout is tied to 0.

module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int TIMEOUT_TICKS = 640
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     baud_pulse,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pe_in,
    input  logic                     fe_in,
    input  logic                     bi_in,
    input  logic                     pop,
    input  logic                     fifo_en,
    input  logic                     fifo_clr,
    input  logic [1:0]               trig_lvl,
    input  logic                     lsr_rd,
    output logic [7:0]               dout,
    output logic                     dout_pe,
    output logic                     dout_fe,
    output logic                     dout_bi,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun,
    output logic                     trig,
    output logic                     err_in_fifo,
    output logic                     timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] err_q, err_d;
    logic             overrun_q, overrun_d;
    logic             fifo_en_q;

    rx_entry_t        mem_q [DEPTH];
    rx_entry_t        wr_entry;
    rx_entry_t        head;

    logic [CW-1:0]    cap;
    logic             is_empty;
    logic             is_full;
    logic             flush;
    logic             do_push;
    logic             do_pop;
    logic             drop;

    logic [7:0]       thr_raw;
    logic [7:0]       thr_eff;
    logic [7:0]       cap8;
    logic [7:0]       count8;

    // A mode change flushes, exactly like an explicit clear.
    assign flush    = fifo_clr | (fifo_en ^ fifo_en_q);

    assign cap      = fifo_en ? CW'(DEPTH) : CW'(1);
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == cap);

    assign do_pop   = pop & ~is_empty & ~flush;
    // A full FIFO still accepts a push when a pop frees a slot the same cycle.
    assign do_push  = push & ~flush & (~is_full | do_pop);
    assign drop     = push & ~flush & is_full & ~do_pop;

    assign wr_entry = '{bi: bi_in, fe: fe_in, pe: pe_in, data: din};

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_d     = err_q;
        overrun_d = overrun_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            err_d    = '0;
        end else begin
            // Clear the popped slot before setting the pushed one: when full
            // both pointers address the same slot.
            if (do_pop) begin
                rd_ptr_d        = rd_ptr_q + 1'b1;
                err_d[rd_ptr_q] = 1'b0;
            end
            if (do_push) begin
                wr_ptr_d        = wr_ptr_q + 1'b1;
                err_d[wr_ptr_q] = pe_in | fe_in | bi_in;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        // A discarded push wins over a same-cycle LSR read.
        if (lsr_rd) begin
            overrun_d = 1'b0;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_q     <= '0;
            overrun_q <= 1'b0;
            fifo_en_q <= fifo_en;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_q     <= err_d;
            overrun_q <= overrun_d;
            fifo_en_q <= fifo_en;
        end
    end

    // Storage is not reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign head    = is_empty ? '0 : mem_q[rd_ptr_q];
    assign dout    = head.data;
    assign dout_pe = head.pe;
    assign dout_fe = head.fe;
    assign dout_bi = head.bi;

    assign empty       = is_empty;
    assign full        = is_full;
    assign count       = count_q;
    assign overrun     = overrun_q;
    assign err_in_fifo = |err_q;

    // Threshold is clamped to capacity so a level above DEPTH still fires.
    assign thr_raw = trig_threshold(trig_lvl_e'(trig_lvl));
    assign cap8    = 8'(cap);
    assign count8  = 8'(count_q);
    assign thr_eff = (thr_raw > cap8) ? cap8 : thr_raw;
    assign trig    = fifo_en ? (count8 >= thr_eff) : ~is_empty;

`ifdef UART_RX_TIMEOUT_EN
    uart_rx_timeout #(
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_timeout (
        .clk        (clk),
        .rst        (rst),
        .baud_pulse (baud_pulse),
        .empty      (is_empty),
        .activity   (push | pop | flush),
        .timeout    (timeout)
    );
`else
    logic unused_timeout_in;
    assign unused_timeout_in = baud_pulse ^ (TIMEOUT_TICKS == 0);
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo.
// Scoreboard queue of expected entries; one task per scenario.

module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int TO    = 640;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          baud_pulse = 1'b0;
    logic          push = 1'b0;
    logic [7:0]    din = '0;
    logic          pe_in = 1'b0;
    logic          fe_in = 1'b0;
    logic          bi_in = 1'b0;
    logic          pop = 1'b0;
    logic          fifo_en = 1'b1;
    logic          fifo_clr = 1'b0;
    logic [1:0]    trig_lvl = 2'b00;
    logic          lsr_rd = 1'b0;
    logic [7:0]    dout;
    logic          dout_pe, dout_fe, dout_bi;
    logic          empty, full;
    logic [CW-1:0] count;
    logic          overrun, trig, err_in_fifo, timeout;

    int checks = 0;
    int failures = 0;
    logic [10:0] exp_q[$];
    logic [10:0] exp;
    logic [10:0] head;

    assign head = {dout_bi, dout_fe, dout_pe, dout};

    uart_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT_TICKS(TO)) dut (
        .clk(clk), .rst(rst), .baud_pulse(baud_pulse),
        .push(push), .din(din), .pe_in(pe_in), .fe_in(fe_in), .bi_in(bi_in),
        .pop(pop), .fifo_en(fifo_en), .fifo_clr(fifo_clr),
        .trig_lvl(trig_lvl), .lsr_rd(lsr_rd),
        .dout(dout), .dout_pe(dout_pe), .dout_fe(dout_fe), .dout_bi(dout_bi),
        .empty(empty), .full(full), .count(count),
        .overrun(overrun), .trig(trig), .err_in_fifo(err_in_fifo),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // flags = {bi, fe, pe}
    task automatic push_byte(input logic [7:0] d, input logic [2:0] f);
        push = 1'b1;
        din = d;
        {bi_in, fe_in, pe_in} = f;
        tick();
        push = 1'b0;
        {bi_in, fe_in, pe_in} = 3'b000;
    endtask

    task automatic pop_one;
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic reset_dut;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset;
        fifo_en = 1'b1;
        trig_lvl = 2'b00;
        reset_dut();
        checks++;
        if ({empty, full, count, trig, overrun, err_in_fifo, timeout}
            !== {1'b1, 1'b0, CW'(0), 1'b0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_flags: got e=%b f=%b c=%0d t=%b o=%b err=%b to=%b",
                     empty, full, count, trig, overrun, err_in_fifo, timeout);
        end
        checks++;
        if (head !== 11'd0) begin
            failures++;
            $display("FAIL reset_dout: got %h want 000", head);
        end
    endtask

    task automatic test_order;
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            push_byte(8'h41 + 8'(i), 3'b000);
            exp_q.push_back({3'b000, 8'h41 + 8'(i)});
        end
        checks++;
        if (count !== CW'(3)) begin
            failures++;
            $display("FAIL order_count: got %0d want 3", count);
        end
        for (int i = 0; i < 3; i++) begin
            exp = exp_q.pop_front();
            checks++;
            if (head !== exp) begin
                failures++;
                $display("FAIL order_pop%0d: got %h want %h", i, head, exp);
            end
            pop_one();
        end
        checks++;
        if (empty !== 1'b1 || dout !== 8'h00) begin
            failures++;
            $display("FAIL order_empty: got e=%b d=%h want e=1 d=00", empty, dout);
        end
        pop_one();
        checks++;
        if (count !== CW'(0)) begin
            failures++;
            $display("FAIL pop_underflow: got %0d want 0", count);
        end
    endtask

    task automatic test_overrun;
        reset_dut();
        for (int i = 0; i < 17; i++) begin
            push_byte(8'h60 + 8'(i), 3'b000);
            if (exp_q.size() < DEPTH) exp_q.push_back({3'b000, 8'h60 + 8'(i)});
            if (i == 15) begin
                checks++;
                if (full !== 1'b1 || overrun !== 1'b0) begin
                    failures++;
                    $display("FAIL full16: got f=%b o=%b want f=1 o=0", full, overrun);
                end
            end
        end
        checks++;
        if (overrun !== 1'b1 || count !== CW'(16)) begin
            failures++;
            $display("FAIL overrun17: got o=%b c=%0d want o=1 c=16", overrun, count);
        end
        lsr_rd = 1'b1;
        push_byte(8'hEE, 3'b000);
        lsr_rd = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_lsr_race: got %b want 1", overrun);
        end
        lsr_rd = 1'b1;
        tick();
        lsr_rd = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clear: got %b want 0", overrun);
        end
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if (head !== exp) begin
                failures++;
                $display("FAIL overrun_drain: got %h want %h", head, exp);
            end
            pop_one();
        end
    endtask

    task automatic test_full_push_pop;
        reset_dut();
        for (int i = 0; i < DEPTH; i++) begin
            push_byte(8'h80 + 8'(i), 3'b000);
            exp_q.push_back({3'b000, 8'h80 + 8'(i)});
        end
        exp = exp_q.pop_front();
        checks++;
        if (head !== exp) begin
            failures++;
            $display("FAIL fpp_head: got %h want %h", head, exp);
        end
        pop = 1'b1;
        push_byte(8'h55, 3'b000);
        pop = 1'b0;
        exp_q.push_back({3'b000, 8'h55});
        checks++;
        if (count !== CW'(16) || full !== 1'b1 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL fpp_count: got c=%0d f=%b o=%b want c=16 f=1 o=0",
                     count, full, overrun);
        end
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if (head !== exp) begin
                failures++;
                $display("FAIL fpp_drain: got %h want %h", head, exp);
            end
            pop_one();
        end
    endtask

    task automatic test_trig;
        reset_dut();
        trig_lvl = 2'b01;
        for (int i = 0; i < 4; i++) begin
            push_byte(8'hA0 + 8'(i), 3'b000);
            checks++;
            if (trig !== (i == 3)) begin
                failures++;
                $display("FAIL trig_push%0d: got %b want %b", i, trig, (i == 3));
            end
        end
        pop_one();
        checks++;
        if (trig !== 1'b0) begin
            failures++;
            $display("FAIL trig_pop: got %b want 0", trig);
        end
        trig_lvl = 2'b00;
    endtask

    task automatic test_err;
        reset_dut();
        push_byte(8'h10, 3'b010);
        push_byte(8'h20, 3'b000);
        checks++;
        if (dout_fe !== 1'b1 || err_in_fifo !== 1'b1 || dout !== 8'h10) begin
            failures++;
            $display("FAIL err_head: got fe=%b err=%b d=%h want 1 1 10",
                     dout_fe, err_in_fifo, dout);
        end
        pop_one();
        checks++;
        if (dout_fe !== 1'b0 || err_in_fifo !== 1'b0 || dout !== 8'h20) begin
            failures++;
            $display("FAIL err_pop: got fe=%b err=%b d=%h want 0 0 20",
                     dout_fe, err_in_fifo, dout);
        end
    endtask

    task automatic test_clr;
        reset_dut();
        push_byte(8'h01, 3'b100);
        push_byte(8'h02, 3'b000);
        fifo_clr = 1'b1;
        pop = 1'b1;
        push_byte(8'h03, 3'b000);
        fifo_clr = 1'b0;
        pop = 1'b0;
        checks++;
        if ({empty, count, err_in_fifo, dout} !== {1'b1, CW'(0), 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL clr: got e=%b c=%0d err=%b d=%h want 1 0 0 00",
                     empty, count, err_in_fifo, dout);
        end
        push_byte(8'h04, 3'b000);
        rst = 1'b1;
        push = 1'b1;
        tick();
        push = 1'b0;
        rst = 1'b0;
        checks++;
        if (empty !== 1'b1 || count !== CW'(0)) begin
            failures++;
            $display("FAIL midreset: got e=%b c=%0d want 1 0", empty, count);
        end
    endtask

    task automatic test_single_mode;
        reset_dut();
        push_byte(8'h11, 3'b000);
        fifo_en = 1'b0;
        trig_lvl = 2'b11;
        tick();
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL mode_flush: got e=%b want 1", empty);
        end
        pop = 1'b1;
        push_byte(8'h22, 3'b000);
        pop = 1'b0;
        checks++;
        if ({count, full, trig, dout} !== {CW'(1), 1'b1, 1'b1, 8'h22}) begin
            failures++;
            $display("FAIL single_push: got c=%0d f=%b t=%b d=%h want 1 1 1 22",
                     count, full, trig, dout);
        end
        push_byte(8'h33, 3'b000);
        checks++;
        if (overrun !== 1'b1 || dout !== 8'h22) begin
            failures++;
            $display("FAIL single_overrun: got o=%b d=%h want 1 22", overrun, dout);
        end
        pop_one();
        checks++;
        if (empty !== 1'b1 || trig !== 1'b0) begin
            failures++;
            $display("FAIL single_pop: got e=%b t=%b want 1 0", empty, trig);
        end
        fifo_en = 1'b1;
        trig_lvl = 2'b00;
        tick();
    endtask

    task automatic test_timeout;
        reset_dut();
        push_byte(8'h77, 3'b000);
        baud_pulse = 1'b1;
        for (int i = 0; i < TO - 1; i++) tick();
        baud_pulse = 1'b0;
`ifdef UART_RX_TIMEOUT_EN
        checks++;
        if (timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early: got %b want 0", timeout);
        end
        baud_pulse = 1'b1;
        tick();
        baud_pulse = 1'b0;
        checks++;
        if (timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_set: got %b want 1", timeout);
        end
        tick();
        checks++;
        if (timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_hold: got %b want 1", timeout);
        end
        pop_one();
        checks++;
        if (timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear: got %b want 0", timeout);
        end
`else
        baud_pulse = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        baud_pulse = 1'b0;
        checks++;
        if (timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_tied: got %b want 0", timeout);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_order();
        test_overrun();
        test_full_push_pop();
        test_trig();
        test_err();
        test_clr();
        test_single_mode();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
